// File: rtl/prefix_add_result_buffer.sv
// Valid/ready wrapper for a fixed-latency, non-stallable prefix adder. Operands
// pass straight through, and a valid delay line marks the real results. Those
// results land in a FIFO whose space is reserved up front by occupancy credits.
module prefix_add_result_buffer #(
  parameter int N     = 5,
  parameter int LAT   = N + 1,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**N-1:0]   a_in,
  input  logic [2**N-1:0]   b_in,
  input  logic              cin_in,
  output logic [2**N-1:0]   add_a,
  output logic [2**N-1:0]   add_b,
  output logic              add_cin,
  input  logic [2**N-1:0]   add_s,
  input  logic              add_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**N-1:0]   out_sum,
  output logic              out_cout
);

  localparam int W  = 2**N;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1.
  // A producer holds its data stable while valid & !ready. in_ready depends only on
  // registered state.
  logic          fire;
  logic          pop;
  logic          push;
  logic          full;
  logic [LAT-1:0] v;
  logic [CW-1:0] occ;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [W:0]    mem [DEPTH];

  assign add_a   = a_in;
  assign add_b   = b_in;
  assign add_cin = cin_in;

  assign in_ready  = (occ < CW'(DEPTH));
  assign fire      = in_valid & in_ready;
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = v[LAT-1];
  assign full      = (count == CW'(DEPTH));

  assign out_sum  = mem[rd_ptr][W-1:0];
  assign out_cout = mem[rd_ptr][W];

  always_ff @(posedge clk) begin
    if (reset) begin
      v <= '0;
    end else begin
      v[0] <= fire;
      for (int k = 1; k < LAT; k++) v[k] <= v[k-1];
    end
  end

  // occ counts every accepted transaction not yet popped, in flight or stored.
  // Holding it at DEPTH or below guarantees the FIFO has room for each push.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ <= '0;
    end else if (fire && !pop) begin
      occ <= occ + CW'(1);
    end else if (!fire && pop) begin
      occ <= occ - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {add_cout, add_s};
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && full)) else $error("push into full result FIFO");
    end
  end

endmodule

// File: tb/tb_prefix_add_result_buffer.sv
// Bench for prefix_add_result_buffer. A behavioural LAT-cycle adder stands in for
// the real adder. A queue-based model predicts results, arrival cycles and credits.
module tb_prefix_add_result_buffer;
  localparam int N     = 5;
  localparam int LAT   = N + 1;
  localparam int DEPTH = 8;
  localparam int W     = 2**N;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_s;
  logic         add_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;

  prefix_add_result_buffer #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  always #5 clk = ~clk;

  // Stand-in adder: samples every edge, result valid LAT cycles later.
  logic [W:0] pipe [LAT];
  assign add_s    = pipe[LAT-1][W-1:0];
  assign add_cout = pipe[LAT-1][W];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  logic [W:0] exp_q[$];
  int         rdy_q[$];
  int         cyc;
  int         n_checks;
  int         n_fail;
  int         dut_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock with full model checking. The model says valid when a result's arrival
  // cycle (accept + LAT + 1) has passed, and ready while fewer than DEPTH are outstanding.
  task automatic cycle();
    logic exp_v, exp_r, f, p;
    exp_v = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
    exp_r = (exp_q.size() < DEPTH);
    check("out_valid", out_valid, exp_v);
    check("in_ready", in_ready, exp_r);
    if (exp_v) check("out_data", {out_cout, out_sum}, exp_q[0]);
    f = in_valid && exp_r;
    p = exp_v && out_ready;
    if (in_valid && in_ready) dut_acc++;
    if (p) begin
      void'(exp_q.pop_front());
      void'(rdy_q.pop_front());
    end
    if (f) begin
      exp_q.push_back({1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, cin_in});
      rdy_q.push_back(cyc + LAT + 1);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    exp_q.delete();
    rdy_q.delete();
  endtask

  task automatic rand_ops();
    a_in   = $urandom;
    b_in   = $urandom;
    cin_in = 1'($urandom_range(0, 1));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    dut_acc   = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    cin_in    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);

    // Single add, first valid exactly 7 cycles after accept, for one cycle.
    out_ready = 1'b1;
    a_in = 32'h0000_0003; b_in = 32'h0000_0004; cin_in = 1'b1; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (LAT) cycle();
    check("single_valid", out_valid, 1);
    check("single_result", {out_cout, out_sum}, 33'h0_0000_0008);
    cycle();
    check("single_one_cycle", out_valid, 0);

    // Carry out.
    a_in = 32'hFFFF_FFFF; b_in = 32'h0000_0001; cin_in = 1'b0; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (LAT) cycle();
    check("carry_valid", out_valid, 1);
    check("carry_result", {out_cout, out_sum}, 33'h1_0000_0000);
    cycle();

    // Streaming: 100 back-to-back with no backpressure.
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_ops();
      check("stream_in_ready", in_ready, 1);
      cycle();
    end
    in_valid = 1'b0;
    repeat (LAT + 3) cycle();

    // Backpressure: exactly DEPTH accepts, then stall; drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    dut_acc   = 0;
    for (int i = 0; i < 14; i++) begin
      rand_ops();
      cycle();
    end
    check("bp_accepts", dut_acc, DEPTH);
    check("bp_in_ready_low", in_ready, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    check("bp_ready_after_pop", in_ready, 1);
    repeat (DEPTH + 2) cycle();

    // Full credit with FIFO partially filled, then mixed push/pop/fire traffic.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 9; i++) begin
      rand_ops();
      cycle();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rand_ops();
      cycle();
    end
    for (int i = 0; i < 200; i++) begin
      rand_ops();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + LAT + 2) cycle();

    // Reset with 2 results buffered and 3 still in the adder.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_ops();
      cycle();
    end
    in_valid = 1'b0;
    repeat (3) cycle();
    check("pre_reset_valid", out_valid, 1);
    do_reset();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_sum", {out_cout, out_sum}, 0);
    out_ready = 1'b1;
    repeat (LAT + 10) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
